uart_word_loader: RTL and testbench

- Parametrised successor to the current UART-to-IRAM byte assembler.
- Consumes bytes from the UART RX FIFO and parses a framed load command: sync byte, start address, word count, payload and checksum.
- Assembles payload bytes into WORD_W-bit words and issues one-cycle IRAM write strobes with an auto-incrementing address.
- Sits between the uart instance and micro's iram_wa/iram_din/iram_wen port; reports busy, done, checksum error and inter-byte timeout.

---
 rtl/uart_loader_pkg.sv | 18 +
 rtl/uart_word_loader_word_packer.sv | 44 ++++
 rtl/uart_word_loader.sv | 156 +++++++++++++++
 tb/tb_uart_word_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared state encodings, sync default and address sizing for the UART word loader
package uart_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_COUNT = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_CSUM  = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int calc_abytes(input int addr_w);
    return (addr_w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_word_loader_word_packer.sv
// rtl/uart_word_loader_word_packer.sv - packs a byte stream into WORD_W-bit words in either byte order
module word_packer #(
  parameter int WORD_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int BPW = WORD_W / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORD_W-1:0] sh;
  logic [CW-1:0]     cnt;
  logic [WORD_W+7:0] cat_lo;
  logic [WORD_W+7:0] cat_hi;
  logic              last;

  // MSB_FIRST shifts left so the first byte ends on top; otherwise shift right
  assign cat_lo     = {sh, byte_data};
  assign cat_hi     = {byte_data, sh};
  assign word_data  = MSB_FIRST ? cat_lo[WORD_W-1:0] : cat_hi[WORD_W+7:8];
  assign last       = (cnt == CW'(BPW - 1));
  assign word_valid = byte_valid && last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sh  <= '0;
      cnt <= '0;
    end else if (byte_valid) begin
      sh  <= word_data;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - framed UART-to-IRAM word loader; optional byte echo under LOADER_ECHO_EN
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int         WORD_W      = 16,
  parameter int         ADDR_W      = 8,
  parameter bit         MSB_FIRST   = 1'b1,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_empty,
  input  logic [7:0]        rx_data,
  output logic              rd_uart,
  output logic [ADDR_W-1:0] iram_wa,
  output logic [WORD_W-1:0] iram_din,
  output logic              iram_wen,
  output logic              busy,
  output logic              done,
  output logic              err_csum,
  output logic              err_tmo,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  input  logic              tx_full
);

  localparam int            ABYTES   = calc_abytes(ADDR_W);
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        abyte_cnt;
  logic [8:0]        words_left;
  logic [7:0]        sum;
  logic [TW-1:0]     tmo_cnt;

  logic              accept;
  logic [7:0]        sum_next;
  logic [ADDR_W+7:0] addr_shift;
  logic              tmo_hit;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;

  assign accept     = !rx_empty;
  assign rd_uart    = accept;
  assign sum_next   = sum + rx_data;
  assign addr_shift = {addr, rx_data};
  // a byte arriving on the expiry cycle wins over the timeout
  assign tmo_hit    = busy && !accept && (tmo_cnt == TMO_LAST);

  word_packer #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != ST_DATA),
    .byte_valid (accept && (state == ST_DATA)),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr       <= '0;
      abyte_cnt  <= '0;
      words_left <= '0;
      sum        <= '0;
      tmo_cnt    <= '0;
      iram_wa    <= '0;
      iram_din   <= '0;
      iram_wen   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_csum   <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      iram_wen <= 1'b0;
      done     <= 1'b0;
      tmo_cnt  <= (!busy || accept) ? '0 : tmo_cnt + 1'b1;

      if (word_valid) begin
        iram_wen <= 1'b1;
        iram_din <= word_data;
        iram_wa  <= addr;
        addr     <= addr + 1'b1;
      end

      if (tmo_hit) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        err_tmo <= 1'b1;
      end else if (accept) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state     <= ST_ADDR;
              busy      <= 1'b1;
              err_csum  <= 1'b0;
              err_tmo   <= 1'b0;
              sum       <= '0;
              abyte_cnt <= '0;
            end
          end
          ST_ADDR: begin
            addr <= addr_shift[ADDR_W-1:0];
            sum  <= sum_next;
            if (abyte_cnt == 2'(ABYTES - 1)) state <= ST_COUNT;
            else abyte_cnt <= abyte_cnt + 1'b1;
          end
          ST_COUNT: begin
            words_left <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            sum        <= sum_next;
            state      <= ST_DATA;
          end
          ST_DATA: begin
            sum <= sum_next;
            if (word_valid) begin
              words_left <= words_left - 1'b1;
              if (words_left == 9'd1) state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (sum_next == 8'd0) done <= 1'b1;
            else err_csum <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef LOADER_ECHO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr   <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_wr <= accept && !tx_full;
      if (accept && !tx_full) tx_data <= rx_data;
    end
  end
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign tx_wr          = 1'b0;
  assign tx_data        = '0;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// tb/tb_uart_word_loader.sv - directed bench for uart_word_loader (big- and little-endian instances)
module tb_uart_word_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_full = 1'b0;

  logic        rd_a, wen_a, busy_a, done_a, ecs_a, etm_a, txw_a;
  logic [7:0]  wa_a, txd_a;
  logic [15:0] din_a;
  logic        rd_b, wen_b, busy_b, done_b, ecs_b, etm_b, txw_b;
  logic [7:0]  wa_b, txd_b;
  logic [15:0] din_b;

  int checks = 0;
  int failures = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [23:0] wq_a[$];
  logic [23:0] wq_b[$];
  logic [23:0] got;

  uart_word_loader dut_a (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_a),
    .iram_wa(wa_a), .iram_din(din_a), .iram_wen(wen_a), .busy(busy_a), .done(done_a),
    .err_csum(ecs_a), .err_tmo(etm_a), .tx_wr(txw_a), .tx_data(txd_a), .tx_full(tx_full)
  );

  uart_word_loader #(.MSB_FIRST(1'b0), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_b),
    .iram_wa(wa_b), .iram_din(din_b), .iram_wen(wen_b), .busy(busy_b), .done(done_b),
    .err_csum(ecs_b), .err_tmo(etm_b), .tx_wr(txw_b), .tx_data(txd_b), .tx_full(tx_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wen_a) wq_a.push_back({wa_a, din_a});
    if (wen_b) wq_b.push_back({wa_b, din_b});
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_empty = 1'b0;
    rx_data  = b;
  endtask

  task automatic stop();
    @(negedge clk);
    rx_empty = 1'b1;
  endtask

  task automatic clear_log();
    wq_a.delete();
    wq_b.delete();
    done_cnt_a = 0;
    done_cnt_b = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({wen_a, busy_a, done_a, ecs_a, etm_a, rd_a} !== 6'b0) begin failures++; $display("FAIL reset_flags: got %b expected 000000", {wen_a, busy_a, done_a, ecs_a, etm_a, rd_a}); end
    checks++; if ({wa_a, din_a} !== 24'h0) begin failures++; $display("FAIL reset_bus: got %h expected 000000", {wa_a, din_a}); end
    checks++; if ({txw_a, txd_a} !== 9'h0) begin failures++; $display("FAIL reset_echo: got %h expected 000", {txw_a, txd_a}); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    clear_log();
    send(8'h00); send(8'hFF); send(8'h3C); send(8'hA5);
    #1;
    checks++; if (rd_a !== 1'b1) begin failures++; $display("FAIL rd_uart: got %b expected 1", rd_a); end
    send(8'h10);
    #1;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL busy_after_sync: got %b expected 1", busy_a); end
    // 10+02+12+34+56+78 = 0x126 -> checksum byte 0xDA
    send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'hDA);
    stop();
    repeat (3) @(negedge clk);
    checks++; if (wq_a.size() !== 2) begin failures++; $display("FAIL basic_nwrites: got %0d expected 2", wq_a.size()); end
    got = (wq_a.size() > 0) ? wq_a[0] : 24'hxxxxxx;
    checks++; if (got !== 24'h10_1234) begin failures++; $display("FAIL basic_w0: got %h expected 101234", got); end
    got = (wq_a.size() > 1) ? wq_a[1] : 24'hxxxxxx;
    checks++; if (got !== 24'h11_5678) begin failures++; $display("FAIL basic_w1: got %h expected 115678", got); end
    got = (wq_b.size() > 0) ? wq_b[0] : 24'hxxxxxx;
    checks++; if (got !== 24'h10_3412) begin failures++; $display("FAIL le_w0: got %h expected 103412", got); end
    got = (wq_b.size() > 1) ? wq_b[1] : 24'hxxxxxx;
    checks++; if (got !== 24'h11_7856) begin failures++; $display("FAIL le_w1: got %h expected 117856", got); end
    checks++; if (done_cnt_a !== 1 || done_cnt_b !== 1) begin failures++; $display("FAIL basic_done: got %0d/%0d expected 1/1", done_cnt_a, done_cnt_b); end
    checks++; if ({busy_a, ecs_a, etm_a} !== 3'b000) begin failures++; $display("FAIL basic_status: got %b expected 000", {busy_a, ecs_a, etm_a}); end
  endtask

  task automatic test_wrap();
    clear_log();
    // FF+02+01+02+03+04 = 0x10B -> checksum byte 0xF5
    send(8'hA5); send(8'hFF); send(8'h02); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hF5);
    stop();
    repeat (3) @(negedge clk);
    got = (wq_a.size() > 0) ? wq_a[0] : 24'hxxxxxx;
    checks++; if (got !== 24'hFF_0102) begin failures++; $display("FAIL wrap_w0: got %h expected ff0102", got); end
    got = (wq_a.size() > 1) ? wq_a[1] : 24'hxxxxxx;
    checks++; if (got !== 24'h00_0304) begin failures++; $display("FAIL wrap_w1: got %h expected 000304", got); end
    checks++; if (done_cnt_a !== 1) begin failures++; $display("FAIL wrap_done: got %0d expected 1", done_cnt_a); end
  endtask

  task automatic test_bad_csum();
    clear_log();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h00);
    stop();
    repeat (3) @(negedge clk);
    checks++; if (wq_a.size() !== 2) begin failures++; $display("FAIL bad_nwrites: got %0d expected 2", wq_a.size()); end
    checks++; if ({ecs_a, busy_a} !== 2'b10) begin failures++; $display("FAIL bad_err: got %b expected 10", {ecs_a, busy_a}); end
    checks++; if (done_cnt_a !== 0) begin failures++; $display("FAIL bad_done: got %0d expected 0", done_cnt_a); end
    send(8'hA5);
    stop();
    #1;
    checks++; if ({ecs_a, ecs_b, busy_a} !== 3'b001) begin failures++; $display("FAIL sync_clears_err: got %b expected 001", {ecs_a, ecs_b, busy_a}); end
  endtask

  task automatic test_timeout();
    clear_log();
    send(8'h10); send(8'h01); send(8'h12);
    stop();
    repeat (90) @(negedge clk);
    checks++; if ({etm_b, busy_b} !== 2'b01) begin failures++; $display("FAIL tmo_early: got %b expected 01", {etm_b, busy_b}); end
    repeat (20) @(negedge clk);
    checks++; if ({etm_b, busy_b} !== 2'b10) begin failures++; $display("FAIL tmo_fire: got %b expected 10", {etm_b, busy_b}); end
    checks++; if (wq_b.size() !== 0) begin failures++; $display("FAIL tmo_nowrite: got %0d expected 0", wq_b.size()); end
    checks++; if ({etm_a, busy_a} !== 2'b01) begin failures++; $display("FAIL long_tmo_holds: got %b expected 01", {etm_a, busy_a}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    clear_log();
    send(8'hA5); send(8'h10); send(8'h01); send(8'h12);
    stop();
    #1;
    checks++; if ({busy_a, busy_b} !== 2'b11) begin failures++; $display("FAIL mid_busy: got %b expected 11", {busy_a, busy_b}); end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if ({wen_a, busy_a, done_a, ecs_a, etm_a, wen_b, busy_b} !== 7'b0) begin failures++; $display("FAIL mid_reset_flags: got %b expected 0000000", {wen_a, busy_a, done_a, ecs_a, etm_a, wen_b, busy_b}); end
    checks++; if ({wa_a, din_a} !== 24'h0) begin failures++; $display("FAIL mid_reset_bus: got %h expected 000000", {wa_a, din_a}); end
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (wq_a.size() + wq_b.size() !== 0) begin failures++; $display("FAIL mid_nowrite: got %0d expected 0", wq_a.size() + wq_b.size()); end
  endtask

  task automatic test_recovery();
    clear_log();
    // 40+01+BE+EF = 0x1EE -> checksum byte 0x12
    send(8'hA5); send(8'h40); send(8'h01); send(8'hBE); send(8'hEF); send(8'h12);
    stop();
    repeat (3) @(negedge clk);
    got = (wq_a.size() > 0) ? wq_a[0] : 24'hxxxxxx;
    checks++; if (got !== 24'h40_BEEF) begin failures++; $display("FAIL rec_w0: got %h expected 40beef", got); end
    got = (wq_b.size() > 0) ? wq_b[0] : 24'hxxxxxx;
    checks++; if (got !== 24'h40_EFBE) begin failures++; $display("FAIL rec_le_w0: got %h expected 40efbe", got); end
    checks++; if (done_cnt_a !== 1 || done_cnt_b !== 1) begin failures++; $display("FAIL rec_done: got %0d/%0d expected 1/1", done_cnt_a, done_cnt_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_bad_csum();
    test_timeout();
    test_reset_mid();
    test_recovery();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
